// File: rtl/axi_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_defs (package)
//  Description : Shared AXI constants, chunking parameters and the issue-FSM
//                state type for the AXI4-to-SDRAM datapaths.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_defs;

   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam int         CHUNK_BEATS   = 4;

   typedef enum logic [0:0] {
      IS_IDLE  = 1'b0,
      IS_CHUNK = 1'b1
   } issue_state_e;

   // Unsupported lengths are rounded up to a whole number of chunks.
   function automatic logic [7:0] legal_arlen(input logic [7:0] arlen);
      return {arlen[7:2], 2'b11};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, power-of-two depth. OUTREG=0 gives a
//                first-word fall-through head; OUTREG=1 serves the head from
//                a flop that is preloaded with the next word.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 16,
   parameter int OUTREG = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // Pointer and occupancy bookkeeping; reset empties the FIFO.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

   // Storage array, no reset needed: contents are only valid behind count.
   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   generate
      if (OUTREG != 0) begin : g_outreg
         logic [WIDTH-1:0] head;
         logic [AW-1:0]    rd_ptr_next;
         assign rd_ptr_next = rd_ptr + AW'(do_rd);
         // Preload the word that will be at the head after this cycle.
         always_ff @(posedge clock) begin
            if (!reset) begin
               head <= '0;
            end else if (do_wr && (wr_ptr == rd_ptr_next)) begin
               head <= wr_data;
            end else begin
               head <= mem[rd_ptr_next];
            end
         end
         assign rd_data = head;
      end else begin : g_fwft
         assign rd_data = mem[rd_ptr];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_rd_path.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_path
//  Description : AXI4 read datapath towards the SDRAM controller. Splits each
//                INCR burst into 4-beat fetch commands, reserves data-FIFO
//                space per chunk, and replays returned data on the R channel
//                with RID/RLAST taken from a per-burst info FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_path
   import axi_defs::*;
#(
   parameter int ADDRS           = 32,
   parameter int WIDTH           = 32,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int CTRL_FIFO_DEPTH = 16,
   parameter int DATA_FIFO_DEPTH = 512
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    axi_arvalid_i,
   output logic                    axi_arready_o,
   input  logic [ADDRS-1:0]        axi_araddr_i,
   input  logic [AXI_ID_WIDTH-1:0] axi_arid_i,
   input  logic [7:0]              axi_arlen_i,
   input  logic [1:0]              axi_arburst_i,
   output logic                    axi_rvalid_o,
   input  logic                    axi_rready_i,
   output logic                    axi_rlast_o,
   output logic [1:0]              axi_rresp_o,
   output logic [AXI_ID_WIDTH-1:0] axi_rid_o,
   output logic [WIDTH-1:0]        axi_rdata_o,
   output logic                    mem_fetch_o,
   input  logic                    mem_accept_i,
   output logic                    mem_rseq_o,
   output logic [AXI_ID_WIDTH-1:0] mem_rdid_o,
   output logic [ADDRS-1:0]        mem_addr_o,
   input  logic                    mem_valid_i,
   output logic                    mem_ready_o,
   input  logic                    mem_last_i,
   input  logic [WIDTH-1:0]        mem_data_i
);

   localparam int DCW        = $clog2(DATA_FIFO_DEPTH) + 1;
   localparam int ICW        = $clog2(CTRL_FIFO_DEPTH) + 1;
   localparam int IW         = AXI_ID_WIDTH + 8;
   localparam int ALIGN_BITS = $clog2(CHUNK_BEATS * WIDTH / 8);
   localparam logic [ADDRS-1:0] CHUNK_BYTES   = ADDRS'(CHUNK_BEATS * WIDTH / 8);
   localparam logic [DCW-1:0]   DEPTH_CNT     = DCW'(DATA_FIFO_DEPTH);
   localparam logic [DCW-1:0]   CHUNK_CNT     = DCW'(CHUNK_BEATS);
   localparam logic [ICW-1:0]   INFO_FULL_CNT = ICW'(CTRL_FIFO_DEPTH);

   issue_state_e state, state_next;

   logic [5:0]     chunks_left;
   logic [DCW-1:0] reserved, reserved_next;
   logic [DCW-1:0] data_cnt_next, space_next;
   logic [ICW-1:0] info_cnt_next;
   logic           fetch_next, arready_next;
   logic [7:0]     beat_idx;
   logic [1:0]     mem_beat_idx;

   logic ar_hs, fetch_hs, beat_in, r_hs, r_last_hs;

   logic [IW-1:0]    info_head;
   logic             info_full, info_empty;
   logic [ICW-1:0]   info_cnt;
   logic             data_full, data_empty;
   logic [DCW-1:0]   data_cnt;

   assign ar_hs     = axi_arvalid_i && axi_arready_o;
   assign fetch_hs  = mem_fetch_o && mem_accept_i;
   assign beat_in   = mem_valid_i && mem_ready_o;
   assign r_hs      = axi_rvalid_o && axi_rready_i;
   assign r_last_hs = r_hs && axi_rlast_o;

   sync_fifo #(
      .WIDTH  (IW),
      .DEPTH  (CTRL_FIFO_DEPTH),
      .OUTREG (0)
   ) u_info_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (ar_hs),
      .wr_data ({axi_arid_i, legal_arlen(axi_arlen_i)}),
      .rd_en   (r_last_hs),
      .rd_data (info_head),
      .full    (info_full),
      .empty   (info_empty),
      .count   (info_cnt)
   );

   sync_fifo #(
      .WIDTH  (WIDTH),
      .DEPTH  (DATA_FIFO_DEPTH),
      .OUTREG (0)
   ) u_data_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (beat_in),
      .wr_data (mem_data_i),
      .rd_en   (r_hs),
      .rd_data (axi_rdata_o),
      .full    (data_full),
      .empty   (data_empty),
      .count   (data_cnt)
   );

   // R channel is driven straight from the FIFO heads.
   assign axi_rvalid_o = !data_empty && !info_empty;
   assign axi_rid_o    = info_head[IW-1:8];
   assign axi_rlast_o  = axi_rvalid_o && (beat_idx == info_head[7:0]);
   assign axi_rresp_o  = AXI_RESP_OKAY;

   // Issue FSM state register.
   always_ff @(posedge clock) begin
      if (!reset) state <= IS_IDLE;
      else        state <= state_next;
   end

   // Next state plus look-ahead of FIFO space so fetch/arready can be registered.
   always_comb begin
      state_next    = state;
      reserved_next = reserved;
      data_cnt_next = data_cnt;
      space_next    = '0;
      info_cnt_next = info_cnt;
      fetch_next    = 1'b0;
      arready_next  = 1'b0;
      case (state)
         IS_IDLE:  if (ar_hs) state_next = IS_CHUNK;
         IS_CHUNK: if (fetch_hs && (chunks_left == 6'd0)) state_next = IS_IDLE;
         default:  state_next = IS_IDLE;
      endcase
      reserved_next = reserved + (fetch_hs ? CHUNK_CNT : '0) - DCW'(beat_in);
      data_cnt_next = data_cnt + DCW'(beat_in) - DCW'(r_hs);
      space_next    = DEPTH_CNT - data_cnt_next - reserved_next;
      info_cnt_next = info_cnt + ICW'(ar_hs) - ICW'(r_last_hs);
      fetch_next    = (state_next == IS_CHUNK) && (space_next >= CHUNK_CNT);
      arready_next  = (state_next == IS_IDLE) && (info_cnt_next != INFO_FULL_CNT);
   end

   // Burst bookkeeping, chunk address stepping and registered handshake outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         axi_arready_o <= 1'b0;
         mem_fetch_o   <= 1'b0;
         mem_ready_o   <= 1'b0;
         mem_rseq_o    <= 1'b0;
         mem_rdid_o    <= '0;
         mem_addr_o    <= '0;
         chunks_left   <= '0;
         reserved      <= '0;
         beat_idx      <= '0;
         mem_beat_idx  <= '0;
      end else begin
         axi_arready_o <= arready_next;
         mem_fetch_o   <= fetch_next;
         mem_ready_o   <= 1'b1;
         reserved      <= reserved_next;
         if (ar_hs) begin
            mem_addr_o  <= axi_araddr_i;
            mem_rdid_o  <= axi_arid_i;
            chunks_left <= axi_arlen_i[7:2];
            mem_rseq_o  <= 1'b0;
         end else if (fetch_hs) begin
            mem_addr_o <= mem_addr_o + CHUNK_BYTES;
            mem_rseq_o <= 1'b1;
            if (chunks_left != 6'd0) chunks_left <= chunks_left - 6'd1;
         end
         if (r_hs) beat_idx <= r_last_hs ? 8'd0 : beat_idx + 8'd1;
         if (beat_in) mem_beat_idx <= mem_beat_idx + 2'd1;
      end
   end

   // Simulation-only protocol checks on requests and returned data.
   always_ff @(posedge clock) begin
      if (reset) begin
         if (ar_hs) begin
            assert (axi_arburst_i == BURST_INCR)
               else $error("axi_rd_path: non-INCR burst treated as INCR");
            assert (axi_arlen_i[1:0] == 2'b11)
               else $error("axi_rd_path: arlen not a multiple of 4 beats");
            assert (axi_araddr_i[ALIGN_BITS-1:0] == '0)
               else $error("axi_rd_path: araddr not chunk aligned");
         end
         assert (!(beat_in && (reserved == '0)))
            else $error("axi_rd_path: read beat without reserved space");
         assert (!(beat_in && data_full))
            else $error("axi_rd_path: data FIFO overflow");
         assert (!(ar_hs && info_full))
            else $error("axi_rd_path: info FIFO overflow");
         if (beat_in) begin
            assert (mem_last_i == (mem_beat_idx == 2'd3))
               else $error("axi_rd_path: mem_last_i out of step with chunk");
         end
      end
   end

endmodule
`default_nettype wire
